// File: rtl/hazard_controller.sv
// ============================================================================
// hazard_controller
// Forwarding selects, stall/bubble and IF/ID flush for the 5-stage MIPS core.
// Optional stall/flush counters: define HAZARD_PERF_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module hazard_controller #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       IDop,
    input  logic [5:0]       EXop,
    input  logic [5:0]       MEMop,
    input  logic [5:0]       WBop,
    input  logic [4:0]       IDrs,
    input  logic [4:0]       IDrt,
    input  logic [4:0]       EXrs,
    input  logic [4:0]       EXrt,
    input  logic [4:0]       EXrd,
    input  logic [4:0]       MEMrt,
    input  logic [4:0]       MEMrd,
    input  logic [4:0]       WBrt,
    input  logic [4:0]       WBrd,
    input  logic             br_taken,
    output logic [1:0]       fwdA_EX,
    output logic [1:0]       fwdB_EX,
    output logic [1:0]       fwdA_ID,
    output logic [1:0]       fwdB_ID,
    output logic             stall,
    output logic             bubble,
    output logic             flush_ifid
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        STALL1 = 1'b1
    } state_t;

    state_t state;

    // Destination register of an instruction; 0 means "writes nothing".
    function automatic logic [4:0] dest_of(input logic [5:0] op,
                                           input logic [4:0] rt,
                                           input logic [4:0] rd);
        logic [4:0] d;
        d = 5'd0;
        case (op)
            OP_RTYPE:                  d = rd;
            OP_LW, OP_ADDI, OP_SLTI:   d = rt;
            default:                   d = 5'd0;
        endcase
        return d;
    endfunction

    function automatic logic uses_rs(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_ADDI) || (op == OP_SLTI) || (op == OP_BEQ) ||
               (op == OP_BNE);
    endfunction

    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) ||
               (op == OP_BNE);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic [4:0] mem_dst,
                                           input logic       mem_is_lw,
                                           input logic [4:0] wb_dst);
        logic [1:0] s;
        s = 2'b00;
        if (mem_dst != 5'd0 && mem_dst == src && !mem_is_lw)
            s = 2'b01;
        else if (wb_dst != 5'd0 && wb_dst == src)
            s = 2'b10;
        return s;
    endfunction

    logic [4:0] ex_dst;
    logic [4:0] mem_dst;
    logic [4:0] wb_dst;
    logic       mem_is_lw;
    logic       ex_is_lw;
    logic       ex_is_alu;
    logic       id_is_br;
    logic       ld_use;
    logic       br_ex_alu;
    logic       br_mem_ld;
    logic       br_ex_ld;
    logic       haz_d1;
    logic       stall_int;

    assign ex_dst    = dest_of(EXop, EXrt, EXrd);
    assign mem_dst   = dest_of(MEMop, MEMrt, MEMrd);
    assign wb_dst    = dest_of(WBop, WBrt, WBrd);
    assign mem_is_lw = (MEMop == OP_LW);
    assign ex_is_lw  = (EXop == OP_LW);
    assign ex_is_alu = (EXop == OP_RTYPE) || (EXop == OP_ADDI) || (EXop == OP_SLTI);
    assign id_is_br  = (IDop == OP_BEQ) || (IDop == OP_BNE);

    assign ld_use    = ex_is_lw && (EXrt != 5'd0) &&
                       ((uses_rs(IDop) && EXrt == IDrs) ||
                        (uses_rt(IDop) && EXrt == IDrt));
    assign br_ex_alu = id_is_br && ex_is_alu && (ex_dst != 5'd0) &&
                       (ex_dst == IDrs || ex_dst == IDrt);
    assign br_mem_ld = id_is_br && mem_is_lw && (MEMrt != 5'd0) &&
                       (MEMrt == IDrs || MEMrt == IDrt);
    assign br_ex_ld  = id_is_br && ex_is_lw && (EXrt != 5'd0) &&
                       (EXrt == IDrs || EXrt == IDrt);
    assign haz_d1    = ld_use || br_ex_alu || br_mem_ld || br_ex_ld;

    // STALL1 holds the pipeline regardless of what detection currently sees.
    assign stall_int = (state == STALL1) || haz_d1;

    always_comb begin
        fwdA_EX    = 2'b00;
        fwdB_EX    = 2'b00;
        fwdA_ID    = 2'b00;
        fwdB_ID    = 2'b00;
        stall      = 1'b0;
        bubble     = 1'b0;
        flush_ifid = 1'b0;
        if (reset) begin
            fwdA_EX    = fwd_sel(EXrs, mem_dst, mem_is_lw, wb_dst);
            fwdB_EX    = fwd_sel(EXrt, mem_dst, mem_is_lw, wb_dst);
            fwdA_ID    = fwd_sel(IDrs, mem_dst, mem_is_lw, wb_dst);
            fwdB_ID    = fwd_sel(IDrt, mem_dst, mem_is_lw, wb_dst);
            stall      = stall_int;
            bubble     = stall_int;
            flush_ifid = !stall_int &&
                         ((IDop == OP_J) || (id_is_br && br_taken));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            case (state)
                RUN:     state <= br_ex_ld ? STALL1 : RUN;
                STALL1:  state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_ifid && flush_cnt != {CNT_W{1'b1}})
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_controller.sv
// Directed self-checking bench for hazard_controller.
`default_nettype none

module tb_hazard_controller;

    localparam logic [5:0] RTYPE = 6'b000000;
    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] BNE   = 6'b000101;
    localparam logic [5:0] J     = 6'b000010;
    localparam logic [5:0] ADDI  = 6'b001000;
    localparam logic [5:0] SLTI  = 6'b001010;
    localparam logic [5:0] NOP   = 6'b111111;

    logic       clk;
    logic       reset;
    logic [5:0] IDop, EXop, MEMop, WBop;
    logic [4:0] IDrs, IDrt, EXrs, EXrt, EXrd, MEMrt, MEMrd, WBrt, WBrd;
    logic       br_taken;
    logic [1:0] fwdA_EX, fwdB_EX, fwdA_ID, fwdB_ID;
    logic       stall, bubble, flush_ifid;
`ifdef HAZARD_PERF_EN
    logic [3:0] stall_cnt, flush_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    hazard_controller #(.CNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .IDop       (IDop),
        .EXop       (EXop),
        .MEMop      (MEMop),
        .WBop       (WBop),
        .IDrs       (IDrs),
        .IDrt       (IDrt),
        .EXrs       (EXrs),
        .EXrt       (EXrt),
        .EXrd       (EXrd),
        .MEMrt      (MEMrt),
        .MEMrd      (MEMrd),
        .WBrt       (WBrt),
        .WBrd       (WBrd),
        .br_taken   (br_taken),
        .fwdA_EX    (fwdA_EX),
        .fwdB_EX    (fwdB_EX),
        .fwdA_ID    (fwdA_ID),
        .fwdB_ID    (fwdB_ID),
        .stall      (stall),
        .bubble     (bubble),
        .flush_ifid (flush_ifid)
`ifdef HAZARD_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        IDop = NOP; EXop = NOP; MEMop = NOP; WBop = NOP;
        IDrs = 0; IDrt = 0; EXrs = 0; EXrt = 0; EXrd = 0;
        MEMrt = 0; MEMrd = 0; WBrt = 0; WBrd = 0;
        br_taken = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;
        // Hazard and forwarding inputs active while reset is held
        IDop = BEQ; IDrs = 9; EXop = LW; EXrt = 9; br_taken = 1'b1;
        MEMop = RTYPE; MEMrd = 5; EXrs = 5;
        #2;
        chk("rst_stall", stall, 0);
        chk("rst_bubble", bubble, 0);
        chk("rst_flush", flush_ifid, 0);
        chk("rst_fwdA_EX", fwdA_EX, 0);
`ifdef HAZARD_PERF_EN
        chk("rst_stall_cnt", stall_cnt, 0);
`endif
        clear_inputs();
        tick();
        reset = 1'b1;
        tick();

        // MEM beats WB; LW in MEM yields to WB
        MEMop = RTYPE; MEMrd = 5; EXrs = 5; WBop = ADDI; WBrt = 5;
        #1;
        chk("fwd_mem_prio", fwdA_EX, 2'b01);
        chk("fwd_rt_none", fwdB_EX, 2'b00);
        chk("fwd_no_stall", stall, 0);
        MEMop = LW;
        #1;
        chk("fwd_mem_lw_wb", fwdA_EX, 2'b10);
        tick();

        // Load-use: one stall cycle, FSM stays in RUN
        clear_inputs();
        EXop = LW; EXrt = 7; IDop = RTYPE; IDrt = 7;
        #1;
        chk("lu_stall", stall, 1);
        chk("lu_bubble", bubble, 1);
        tick();
        clear_inputs();
        #1;
        chk("lu_release", stall, 0);
        tick();

        // Branch on load in EX: two stall cycles, no flush
        IDop = BEQ; IDrs = 9; EXop = LW; EXrt = 9; br_taken = 1'b1;
        #1;
        chk("bld_stall_c1", stall, 1);
        chk("bld_flush_c1", flush_ifid, 0);
        tick();
        EXop = NOP; EXrt = 0;
        #1;
        chk("bld_stall_c2", stall, 1);
        chk("bld_bubble_c2", bubble, 1);
        chk("bld_flush_c2", flush_ifid, 0);
        tick();
        #1;
        chk("bld_stall_c3", stall, 0);
        chk("bld_flush_c3", flush_ifid, 1);
        tick();

        // BNE forwarded from SLTI in MEM, taken
        clear_inputs();
        IDop = BNE; IDrt = 3; MEMop = SLTI; MEMrt = 3; br_taken = 1'b1;
        #1;
        chk("bne_fwdB_ID", fwdB_ID, 2'b01);
        chk("bne_fwdA_ID", fwdA_ID, 2'b00);
        chk("bne_stall", stall, 0);
        chk("bne_flush", flush_ifid, 1);
        tick();

        // Register 0 never forwards; WB forwarding on rt
        clear_inputs();
        WBop = RTYPE; WBrd = 0; EXrs = 0;
        #1;
        chk("r0_fwdA_EX", fwdA_EX, 2'b00);
        WBrd = 4; EXrt = 4;
        #1;
        chk("wb_fwdB_EX", fwdB_EX, 2'b10);
        tick();

        // Jump flushes; not-taken branch does not
        clear_inputs();
        IDop = J;
        #1;
        chk("j_flush", flush_ifid, 1);
        IDop = BEQ; br_taken = 1'b0;
        #1;
        chk("beq_nt_flush", flush_ifid, 0);
        tick();

        // Branch vs ALU result in EX: one cycle
        clear_inputs();
        IDop = BEQ; IDrt = 6; EXop = ADDI; EXrt = 6;
        #1;
        chk("balu_stall", stall, 1);
        tick();
        clear_inputs();
        #1;
        chk("balu_release", stall, 0);
        tick();

        // Reset asserted while in STALL1
        IDop = BEQ; IDrs = 9; EXop = LW; EXrt = 9;
        tick();
        clear_inputs();
        #1;
        chk("s1_stall_before", stall, 1);
        reset = 1'b0;
        #1;
        chk("s1_rst_stall", stall, 0);
`ifdef HAZARD_PERF_EN
        chk("s1_rst_stall_cnt", stall_cnt, 0);
        chk("s1_rst_flush_cnt", flush_cnt, 0);
`endif
        tick();
        reset = 1'b1;
        #1;
        chk("s1_after_rel", stall, 0);
        tick();
        chk("s1_no_residual", stall, 0);

`ifdef HAZARD_PERF_EN
        // Saturation of the 4-bit stall counter
        EXop = LW; EXrt = 7; IDop = RTYPE; IDrt = 7;
        for (int i = 0; i < 20; i++) tick();
        chk("perf_stall_sat", stall_cnt, 4'd15);
        chk("perf_flush_zero", flush_cnt, 4'd0);
        clear_inputs();
        IDop = J;
        tick();
        chk("perf_flush_one", flush_cnt, 4'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/hazard_controller.md
# hazard_controller

Pipeline hazard controller for the 5-stage MIPS core. Sits beside the ID/EX/MEM/WB pipeline registers and decides forwarding-mux selects for the ID-stage branch comparator and the EX-stage ALU, plus stall, bubble-insert and IF/ID flush. A small state machine enforces multi-cycle stalls for branches that depend on loads. Optional saturating counters record stall and flush cycles.

## Interface
- `CNT_W`, 16, width of performance counters (used only with `HAZARD_PERF_EN`)
- `clk`  in  1  pipeline clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `IDop`, `EXop`, `MEMop`, `WBop`  in  6 each  opcode of the instruction in each stage
- `IDrs`, `IDrt`, `EXrs`, `EXrt`, `EXrd`, `MEMrt`, `MEMrd`, `WBrt`, `WBrd`  in  5 each  register fields per stage
- `br_taken`  in  1  ID comparator result for BEQ/BNE, already using the forwarded operands
- `fwdA_EX`, `fwdB_EX`  out  2 each  ALU operand select: 00 regfile, 01 MEM, 10 WB
- `fwdA_ID`, `fwdB_ID`  out  2 each  branch comparator operand select, same encoding
- `stall`  out  1  hold PC and IF/ID
- `bubble`  out  1  load NOP into ID/EX
- `flush_ifid`  out  1  squash the instruction in IF/ID
- `stall_cnt`, `flush_cnt`  out  CNT_W each  performance counters (with `HAZARD_PERF_EN` only)

## Operation
- Opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, BNE 000101, J 000010, ADDI 001000, SLTI 001010. Any other opcode is treated as a NOP: it writes nothing and reads nothing.
- Destination per stage:
  - RTYPE writes rd.
  - LW, ADDI and SLTI write rt.
  - SW, BEQ, BNE and J write nothing.
  - A destination of 0 is never a match.
- Source use:
  - rs is read by RTYPE, LW, SW, ADDI, SLTI, BEQ and BNE.
  - rt is read by RTYPE, SW, BEQ and BNE.
- EX forwarding (`fwdA_EX` for rs, `fwdB_EX` for rt):
  - Select 01 if the MEM destination matches and MEMop is not LW.
  - Otherwise select 10 if the WB destination matches (all writers, including LW).
  - Otherwise 00. MEM has priority over WB.
- ID forwarding (`fwdA_ID`, `fwdB_ID`) uses the same rules against IDrs and IDrt. It is computed for every ID instruction; it only has effect for branches.
- Hazard depth d:
  - d=1, load-use: EXop=LW and EXrt matches a used ID source.
  - d=1, branch vs ALU op in EX: ID is BEQ/BNE, and EX is RTYPE, ADDI or SLTI whose destination matches IDrs or IDrt.
  - d=1, branch vs load in MEM: ID is BEQ/BNE, MEMop=LW, and MEMrt matches.
  - d=2, branch vs load in EX: ID is BEQ/BNE, EXop=LW, and EXrt matches.
  - If several conditions hold, the largest d applies.
- FSM states:
  - RUN: if d≥1, drive `stall`=`bubble`=1. Next state is STALL1 if d=2, otherwise RUN.
  - STALL1: drive `stall`=`bubble`=1 unconditionally, ignoring detection. Next state is RUN.
- Flush: `flush_ifid`=1 when not stalling and either IDop=J, or IDop is BEQ/BNE with `br_taken`=1. Stall has priority; flush is suppressed in any stall cycle.

## Timing
- Forward selects, `stall`, `bubble` and `flush_ifid` are combinational from the stage inputs and the current FSM state, with zero-cycle latency.
- FSM and counters update on the rising edge of `clk`.
- Reset (`reset`=0):
  - FSM goes to RUN and counters clear to 0, asynchronously.
  - While reset is held, `stall`, `bubble`, `flush_ifid` and all selects are forced to 0.
- Deassertion of reset takes effect at the next rising edge.
- Reset during STALL1 returns the FSM to RUN; no residual stall.
- A d=2 hazard gives exactly 2 consecutive stall cycles. In the second cycle the load is in MEM and detection is masked.
- WB-stage write and ID read of the same register in the same cycle is covered by WB→ID forwarding. The register file is not assumed write-first.

## Configuration
- `HAZARD_PERF_EN` defined:
  - `stall_cnt` increments on every cycle with `stall`=1.
  - `flush_cnt` increments on every cycle with `flush_ifid`=1.
  - Both saturate at all-ones and clear on reset.
- `HAZARD_PERF_EN` undefined: both counter ports and their registers are absent. Forwarding, stall and flush behaviour is identical to the defined case.

## Test plan
- MEMop=RTYPE, MEMrd=5, EXrs=5, and WBop=ADDI, WBrt=5 → `fwdA_EX`=01 (MEM wins); then set MEMop=LW → `fwdA_EX`=10.
- EXop=LW, EXrt=7, IDop=RTYPE, IDrt=7 → `stall`=`bubble`=1 for exactly 1 cycle; the FSM stays in RUN.
- IDop=BEQ, IDrs=9, EXop=LW, EXrt=9 → `stall` high for 2 cycles (RUN→STALL1→RUN), and `flush_ifid`=0 throughout even with `br_taken`=1.
- IDop=BNE, IDrt=3, MEMop=SLTI, MEMrt=3, `br_taken`=1 → `fwdB_ID`=01, `stall`=0, `flush_ifid`=1.
- Register-0 check: WBop=RTYPE, WBrd=0, EXrs=0 → `fwdA_EX`=00. Mid-stall check: assert reset in STALL1 → `stall`=0 immediately, counters read 0.
- With `HAZARD_PERF_EN`, CNT_W=4: 20 consecutive stall cycles → `stall_cnt`=15 (saturated).
